// File: rtl/sobel_window_gen.sv
// KSZ x KSZ window generator for a boundary-padded pixel stream (line buffers + column shifter).
// Optional build macro WIN_ZERO_BLANK_EN: zero dout_win whenever dout_hsync is low.
module sobel_window_gen #(
  parameter int KSZ = 3,
  parameter int DW  = 8,
  parameter int IW  = 640,
  parameter int IH  = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din_vsync,
  input  logic                    din_hsync,
  input  logic [DW-1:0]           din,
  output logic                    dout_vsync,
  output logic                    dout_hsync,
  output logic [KSZ*KSZ*DW-1:0]   dout_win
);

  localparam int PW = IW + KSZ - 1;
  localparam int PH = IH + KSZ - 1;
  localparam int AW = $clog2(PW);
  localparam logic [13:0] PW_C  = 14'(PW);
  localparam logic [11:0] PH_C  = 12'(PH);
  localparam logic [13:0] K_COL = 14'(KSZ - 1);
  localparam logic [11:0] K_ROW = 12'(KSZ - 1);

  logic [13:0]           col_cnt_q, col_cnt_d;
  logic [11:0]           row_cnt_q, row_cnt_d;
  logic                  armed_q, armed_d;
  logic                  hs_q, vs_low_q;
  logic                  vs_d1_q, vs_d2_q;
  logic                  vs_rise, hs_fall, pix_ok, pix_valid;
  logic [11:0]           row_eff;
  logic [AW-1:0]         addr;
  logic [KSZ*DW-1:0]     tap_col;

  logic [KSZ*DW-1:0]     s1_tap_q;
  logic                  s1_valid_q;
  logic [13:0]           s1_col_q;
  logic [11:0]           s1_row_q;

  logic [KSZ*KSZ*DW-1:0] win_q, win_d;
  logic                  hsync_q, hsync_d;

  logic [DW-1:0]         lb_mem [KSZ-1][PW];

  // vs_low_q clears on reset, so a vsync still high after reset is not a frame start.
  assign vs_rise   = din_vsync & vs_low_q;
  assign hs_fall   = hs_q & ~din_hsync;
  assign pix_ok    = din_hsync & (col_cnt_q < PW_C);
  assign pix_valid = pix_ok & (armed_q | vs_rise);
  assign row_eff   = vs_rise ? 12'd0 : row_cnt_q;
  assign addr      = col_cnt_q[AW-1:0];

  always_comb begin
    col_cnt_d = col_cnt_q;
    if (!din_hsync)
      col_cnt_d = '0;
    else if (col_cnt_q < PW_C)
      col_cnt_d = col_cnt_q + 14'd1;

    row_cnt_d = row_cnt_q;
    armed_d   = armed_q;
    if (vs_rise) begin
      row_cnt_d = '0;
      armed_d   = 1'b1;
    end else if (armed_q && din_vsync && hs_fall && (row_cnt_q < PH_C)) begin
      row_cnt_d = row_cnt_q + 12'd1;
    end
  end

  always_comb begin
    tap_col = '0;
    for (int k = 0; k < KSZ - 1; k++)
      tap_col[k*DW +: DW] = lb_mem[k][addr];
    tap_col[(KSZ-1)*DW +: DW] = din;
  end

  // Cascade: each buffer hands its old entry to the next older one, newest takes din.
  always_ff @(posedge clk) begin
    if (pix_ok) begin
      for (int k = 0; k < KSZ - 2; k++)
        lb_mem[k][addr] <= lb_mem[k+1][addr];
      lb_mem[KSZ-2][addr] <= din;
    end
  end

  always_comb begin
    win_d = win_q;
    if (s1_valid_q) begin
      for (int r = 0; r < KSZ; r++) begin
        for (int c = 0; c < KSZ; c++) begin
          if (c == KSZ - 1)
            win_d[((r*KSZ)+c)*DW +: DW] = s1_tap_q[r*DW +: DW];
          else
            win_d[((r*KSZ)+c)*DW +: DW] = win_q[((r*KSZ)+c+1)*DW +: DW];
        end
      end
    end
    hsync_d = s1_valid_q && (s1_col_q >= K_COL) && (s1_row_q >= K_ROW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      armed_q    <= 1'b0;
      hs_q       <= 1'b0;
      vs_low_q   <= 1'b0;
      vs_d1_q    <= 1'b0;
      vs_d2_q    <= 1'b0;
      s1_tap_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      win_q      <= '0;
      hsync_q    <= 1'b0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      armed_q    <= armed_d;
      hs_q       <= din_hsync;
      vs_low_q   <= ~din_vsync;
      vs_d1_q    <= din_vsync;
      vs_d2_q    <= vs_d1_q;
      s1_tap_q   <= tap_col;
      s1_valid_q <= pix_valid;
      s1_col_q   <= col_cnt_q;
      s1_row_q   <= row_eff;
      win_q      <= win_d;
      hsync_q    <= hsync_d;
    end
  end

  assign dout_vsync = vs_d2_q;
  assign dout_hsync = hsync_q;

`ifdef WIN_ZERO_BLANK_EN
  assign dout_win = hsync_q ? win_q : '0;
`else
  assign dout_win = win_q;
`endif

endmodule
